// File: rtl/sb_multiport_pkg.sv
// Shared types for the multi-port scoreboard: issue payload, commit view, exception record.
package sb_multiport_pkg;

  localparam int SB_DATA_W     = 64;
  localparam int SB_RA_W       = 5;
  localparam int SB_NR_ENTRIES = 8;
  localparam int SB_TID_W      = $clog2(SB_NR_ENTRIES);

  typedef enum logic [2:0] {
    FU_NONE   = 3'd0,
    FU_ALU    = 3'd1,
    FU_BRANCH = 3'd2,
    FU_LOAD   = 3'd3,
    FU_STORE  = 3'd4,
    FU_MULT   = 3'd5,
    FU_FPU    = 3'd6,
    FU_CSR    = 3'd7
  } fu_t;

  typedef struct packed {
    logic                 valid;
    logic [7:0]           cause;
    logic [SB_DATA_W-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic [SB_RA_W-1:0]   rd;
    logic                 rd_fpr;
    fu_t                  fu;
    logic [SB_DATA_W-1:0] pc;
    logic [7:0]           op;
  } sb_iss_t;

  typedef struct packed {
    sb_iss_t              iss;
    logic [SB_DATA_W-1:0] result;
    exception_t           ex;
    logic                 done;
    logic [SB_TID_W-1:0]  tid;
  } sb_cmt_t;

  // x0 is hardwired zero, so nothing in flight ever produces it
  function automatic logic is_x0(input logic [SB_RA_W-1:0] addr, input logic fpr);
    return (addr == {SB_RA_W{1'b0}}) && !fpr;
  endfunction

endpackage

// File: rtl/sb_multiport_age_find.sv
// Youngest-match selector: scans slots oldest-to-youngest starting at the read pointer.
module sb_multiport_age_find #(
  parameter  int NR_ENTRIES = 8,
  localparam int TID_W      = $clog2(NR_ENTRIES)
) (
  input  logic [NR_ENTRIES-1:0] i_match,
  input  logic [TID_W-1:0]      i_rd_ptr,
  output logic                  o_hit,
  output logic [TID_W-1:0]      o_idx
);

  // later (younger) matches overwrite earlier ones
  always_comb begin
    logic [TID_W-1:0] v_k;
    o_hit = 1'b0;
    o_idx = i_rd_ptr;
    for (int j = 0; j < NR_ENTRIES; j++) begin
      v_k = i_rd_ptr + TID_W'(j);
      if (i_match[v_k]) begin
        o_hit = 1'b1;
        o_idx = v_k;
      end else begin
        o_hit = o_hit;
      end
    end
  end

endmodule

// File: rtl/sb_multiport_chk.sv
// Protocol and configuration checks for sb_multiport (simulation only, no logic).
module sb_multiport_chk
  import sb_multiport_pkg::*;
#(
  parameter int NR_ENTRIES = 8,
  parameter int NR_WB      = 4,
  parameter int NR_COMMIT  = 2,
  parameter int DATA_W     = 64,
  parameter int TID_W      = 3
) (
  input logic                           i_clk,
  input logic                           i_rst_n,
  input logic                           i_flush,
  input logic                           i_flush_young,
  input logic                           i_fy_live,
  input logic [NR_COMMIT-1:0]           i_cmt_valid,
  input logic [NR_COMMIT-1:0]           i_cmt_ack,
  input logic [NR_WB-1:0]               i_wb_valid,
  input logic [NR_WB-1:0][TID_W-1:0]    i_wb_tid
);

  function automatic logic wb_unique(input logic [NR_WB-1:0] v, input logic [NR_WB-1:0][TID_W-1:0] t);
    logic r;
    r = 1'b1;
    for (int a = 0; a < NR_WB; a++)
      for (int b = a + 1; b < NR_WB; b++)
        if (v[a] && v[b] && (t[a] == t[b])) r = 1'b0;
    return r;
  endfunction

  a_cfg: assert property (@(posedge i_clk)
    (NR_ENTRIES >= 2) && ((NR_ENTRIES & (NR_ENTRIES - 1)) == 0) && (NR_COMMIT <= NR_ENTRIES) &&
    (TID_W == SB_TID_W) && (DATA_W == SB_DATA_W));
  a_ack_prefix: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_cmt_ack & (i_cmt_ack + NR_COMMIT'(1))) == '0);
  a_ack_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_cmt_ack & ~i_cmt_valid) == '0);
  a_wb_unique: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !i_flush |-> wb_unique(i_wb_valid, i_wb_tid));
  a_fy_live: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_flush_young && !i_flush) |-> i_fy_live);

endmodule

// File: rtl/sb_multiport.sv
// Multi-port in-order scoreboard: circular buffer from issue to commit with selective flush.
// Define SB_WB_FWD_EN to forward same-cycle write-back results onto the operand read ports.
module sb_multiport
  import sb_multiport_pkg::*;
#(
  parameter  int NR_ENTRIES = SB_NR_ENTRIES,
  parameter  int NR_WB      = 4,
  parameter  int NR_COMMIT  = 2,
  parameter  int NR_RD      = 2,
  parameter  int DATA_W     = SB_DATA_W,
  parameter  int RA_W       = SB_RA_W,
  localparam int TID_W      = $clog2(NR_ENTRIES)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               flush_young_i,
  input  logic [TID_W-1:0]                   flush_tid_i,
  input  logic                               iss_valid_i,
  output logic                               iss_ready_o,
  input  sb_iss_t                            iss_entry_i,
  output logic [TID_W-1:0]                   iss_tid_o,
  input  logic [NR_WB-1:0]                   wb_valid_i,
  input  logic [NR_WB-1:0][TID_W-1:0]        wb_tid_i,
  input  logic [NR_WB-1:0][DATA_W-1:0]       wb_data_i,
  input  exception_t [NR_WB-1:0]             wb_ex_i,
  output logic [NR_COMMIT-1:0]               cmt_valid_o,
  output sb_cmt_t [NR_COMMIT-1:0]            cmt_entry_o,
  input  logic [NR_COMMIT-1:0]               cmt_ack_i,
  input  logic [NR_RD-1:0][RA_W-1:0]         rd_addr_i,
  input  logic [NR_RD-1:0]                   rd_fpr_i,
  output logic [NR_RD-1:0]                   rd_hit_o,
  output logic [NR_RD-1:0]                   rd_ready_o,
  output logic [NR_RD-1:0][DATA_W-1:0]       rd_data_o,
  output logic [TID_W:0]                     count_o
);

  logic [TID_W:0]          r_wr, r_rd;
  logic [NR_ENTRIES-1:0]   r_live;
  sb_cmt_t                 r_mem [NR_ENTRIES];

  logic                    w_full, w_fy, w_issue;
  logic [TID_W-1:0]        w_fy_age;
  logic [TID_W:0]          w_wr_fy, w_nack;
  logic [NR_COMMIT-1:0]    w_ack;
  logic [TID_W-1:0]        w_cidx [NR_COMMIT];
  logic [NR_ENTRIES-1:0]   w_kill;

  assign w_full      = (r_wr ^ r_rd) == {1'b1, {TID_W{1'b0}}};
  assign iss_ready_o = !w_full;
  assign iss_tid_o   = r_wr[TID_W-1:0];
  assign count_o     = r_wr - r_rd;
  assign w_fy        = flush_young_i && !flush_i && r_live[flush_tid_i];
  assign w_issue     = iss_valid_i && !w_full && !flush_i && !w_fy;
  assign w_fy_age    = flush_tid_i - r_rd[TID_W-1:0];
  assign w_wr_fy     = r_rd + {1'b0, w_fy_age} + {{TID_W{1'b0}}, 1'b1};

  // commit window: valid only as an unbroken run from the oldest entry; ack retires its leading prefix
  always_comb begin
    logic v_prev, v_aprev;
    v_prev  = 1'b1;
    v_aprev = 1'b1;
    w_nack  = '0;
    for (int i = 0; i < NR_COMMIT; i++) begin
      w_cidx[i]         = r_rd[TID_W-1:0] + TID_W'(i);
      cmt_valid_o[i]    = v_prev && r_live[w_cidx[i]] && r_mem[w_cidx[i]].done;
      cmt_entry_o[i]    = r_mem[w_cidx[i]];
      cmt_entry_o[i].tid = w_cidx[i];
      w_ack[i]          = v_aprev && cmt_ack_i[i] && cmt_valid_o[i];
      w_nack            = w_nack + {{TID_W{1'b0}}, w_ack[i]};
      v_prev            = cmt_valid_o[i];
      v_aprev           = w_ack[i];
    end
  end

  // kill every slot whose age (distance from rd) exceeds the surviving branch's age
  always_comb begin
    logic [TID_W-1:0] v_age;
    for (int k = 0; k < NR_ENTRIES; k++) begin
      v_age     = TID_W'(k) - r_rd[TID_W-1:0];
      w_kill[k] = w_fy && (v_age > w_fy_age);
    end
  end

  // buffer state: write-back, commit, issue, selective kill (later writes take precedence)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_live <= '0;
      for (int k = 0; k < NR_ENTRIES; k++) r_mem[k] <= '0;
    end else if (flush_i) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_live <= '0;
      for (int k = 0; k < NR_ENTRIES; k++) r_mem[k].done <= 1'b0;
    end else begin
      for (int p = 0; p < NR_WB; p++) begin
        if (wb_valid_i[p] && r_live[wb_tid_i[p]]) begin
          r_mem[wb_tid_i[p]].done   <= 1'b1;
          r_mem[wb_tid_i[p]].result <= wb_data_i[p];
          if (wb_ex_i[p].valid) r_mem[wb_tid_i[p]].ex <= wb_ex_i[p];
        end
      end
      for (int i = 0; i < NR_COMMIT; i++) begin
        if (w_ack[i]) begin
          r_live[w_cidx[i]]      <= 1'b0;
          r_mem[w_cidx[i]].done  <= 1'b0;
        end
      end
      if (w_issue) begin
        r_live[r_wr[TID_W-1:0]]     <= 1'b1;
        r_mem[r_wr[TID_W-1:0]].iss  <= iss_entry_i;
        r_mem[r_wr[TID_W-1:0]].done <= 1'b0;
        r_mem[r_wr[TID_W-1:0]].ex   <= '0;
        r_mem[r_wr[TID_W-1:0]].tid  <= r_wr[TID_W-1:0];
      end
      for (int k = 0; k < NR_ENTRIES; k++) begin
        if (w_kill[k]) begin
          r_live[k]     <= 1'b0;
          r_mem[k].done <= 1'b0;
        end
      end
      r_rd <= r_rd + w_nack;
      r_wr <= w_fy ? w_wr_fy : (r_wr + {{TID_W{1'b0}}, w_issue});
    end
  end

  for (genvar r = 0; r < NR_RD; r++) begin : g_rd
    logic [NR_ENTRIES-1:0] w_match;
    logic                  w_hit;
    logic [TID_W-1:0]      w_sel;

    always_comb begin
      for (int k = 0; k < NR_ENTRIES; k++)
        w_match[k] = r_live[k] && (r_mem[k].iss.rd == rd_addr_i[r]) &&
                     (r_mem[k].iss.rd_fpr == rd_fpr_i[r]) && !is_x0(rd_addr_i[r], rd_fpr_i[r]);
    end

    sb_multiport_age_find #(.NR_ENTRIES(NR_ENTRIES)) u_age (
      .i_match  (w_match),
      .i_rd_ptr (r_rd[TID_W-1:0]),
      .o_hit    (w_hit),
      .o_idx    (w_sel)
    );

    // operand from the youngest producer, optionally bypassing a same-cycle write-back
    always_comb begin
      rd_hit_o[r]   = w_hit;
      rd_ready_o[r] = w_hit && r_mem[w_sel].done && !r_mem[w_sel].ex.valid;
      rd_data_o[r]  = r_mem[w_sel].result;
`ifdef SB_WB_FWD_EN
      for (int p = 0; p < NR_WB; p++) begin
        if (w_hit && wb_valid_i[p] && (wb_tid_i[p] == w_sel) && !wb_ex_i[p].valid) begin
          rd_ready_o[r] = 1'b1;
          rd_data_o[r]  = wb_data_i[p];
        end else begin
          rd_ready_o[r] = rd_ready_o[r];
        end
      end
`endif
    end
  end

  sb_multiport_chk #(
    .NR_ENTRIES (NR_ENTRIES),
    .NR_WB      (NR_WB),
    .NR_COMMIT  (NR_COMMIT),
    .DATA_W     (DATA_W),
    .TID_W      (TID_W)
  ) u_chk (
    .i_clk         (clk_i),
    .i_rst_n       (rst_ni),
    .i_flush       (flush_i),
    .i_flush_young (flush_young_i),
    .i_fy_live     (r_live[flush_tid_i]),
    .i_cmt_valid   (cmt_valid_o),
    .i_cmt_ack     (cmt_ack_i),
    .i_wb_valid    (wb_valid_i),
    .i_wb_tid      (wb_tid_i)
  );

endmodule

// File: tb/tb_sb_multiport.sv
// Directed bench for sb_multiport: full/ready, out-of-order wb, operand reads, selective flush, wrap.
module tb_sb_multiport;
  import sb_multiport_pkg::*;

  localparam int NE = 8, NWB = 4, NC = 2, NRD = 2, TW = 3;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic                      flush_i, flush_young_i, iss_valid_i, iss_ready_o;
  logic [TW-1:0]             flush_tid_i, iss_tid_o;
  sb_iss_t                   iss_entry_i;
  logic [NWB-1:0]            wb_valid_i;
  logic [NWB-1:0][TW-1:0]    wb_tid_i;
  logic [NWB-1:0][63:0]      wb_data_i;
  exception_t [NWB-1:0]      wb_ex_i;
  logic [NC-1:0]             cmt_valid_o, cmt_ack_i;
  sb_cmt_t [NC-1:0]          cmt_entry_o;
  logic [NRD-1:0][4:0]       rd_addr_i;
  logic [NRD-1:0]            rd_fpr_i, rd_hit_o, rd_ready_o;
  logic [NRD-1:0][63:0]      rd_data_o;
  logic [TW:0]               count_o;

  int n_chk = 0;
  int n_fail = 0;
  int exp_iss, exp_cmt, prev_n;
  logic prev_v;

  sb_multiport #(.NR_ENTRIES(NE), .NR_WB(NWB), .NR_COMMIT(NC), .NR_RD(NRD), .DATA_W(64), .RA_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_young_i(flush_young_i),
    .flush_tid_i(flush_tid_i), .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o),
    .iss_entry_i(iss_entry_i), .iss_tid_o(iss_tid_o), .wb_valid_i(wb_valid_i), .wb_tid_i(wb_tid_i),
    .wb_data_i(wb_data_i), .wb_ex_i(wb_ex_i), .cmt_valid_o(cmt_valid_o), .cmt_entry_o(cmt_entry_o),
    .cmt_ack_i(cmt_ack_i), .rd_addr_i(rd_addr_i), .rd_fpr_i(rd_fpr_i), .rd_hit_o(rd_hit_o),
    .rd_ready_o(rd_ready_o), .rd_data_o(rd_data_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0; flush_young_i = 1'b0; flush_tid_i = '0;
    iss_valid_i = 1'b0; iss_entry_i = '0;
    wb_valid_i = '0; wb_tid_i = '0; wb_data_i = '0; wb_ex_i = '0;
    cmt_ack_i = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic fpr);
    iss_valid_i = 1'b1;
    iss_entry_i = '0;
    iss_entry_i.rd = rd;
    iss_entry_i.rd_fpr = fpr;
    iss_entry_i.fu = FU_ALU;
    tick();
    iss_valid_i = 1'b0;
  endtask

  task automatic wb(input int port, input logic [TW-1:0] tid, input logic [63:0] data);
    wb_valid_i[port] = 1'b1;
    wb_tid_i[port] = tid;
    wb_data_i[port] = data;
    tick();
    wb_valid_i = '0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    iss_valid_i = 1'b1;
    tick();
    idle();
    chk("flush_count", count_o, 64'd0);
    chk("flush_ready", iss_ready_o, 64'd1);
    chk("flush_cmt_valid", cmt_valid_o, 64'd0);
  endtask

  initial begin
    idle();
    rd_addr_i = '0; rd_fpr_i = '0;
    rd_addr_i[0] = 5'd5;
    #2;
    chk("rst_count", count_o, 64'd0);
    chk("rst_ready", iss_ready_o, 64'd1);
    chk("rst_cmt_valid", cmt_valid_o, 64'd0);
    chk("rst_rd_hit", rd_hit_o, 64'd0);
    #10 rst_ni = 1'b1;
    tick();
    chk("post_rst_tid", iss_tid_o, 64'd0);

    // 1: fill to full, then commit one
    for (int i = 0; i < 8; i++) begin
      chk("t1_tid", iss_tid_o, 64'(i));
      issue(5'd1, 1'b0);
    end
    chk("t1_count_full", count_o, 64'd8);
    chk("t1_ready_full", iss_ready_o, 64'd0);
    wb(0, 3'd0, 64'h1);
    chk("t1_cmt_valid", cmt_valid_o, 64'b01);
    cmt_ack_i = 2'b01;
    iss_valid_i = 1'b1;
    #1;
    chk("t1_no_comb_unblock", iss_ready_o, 64'd0);
    tick();
    idle();
    chk("t1_count_7", count_o, 64'd7);
    chk("t1_ready_after", iss_ready_o, 64'd1);
    chk("t1_tid_wrap", iss_tid_o, 64'd0);
    do_flush();

    // 2: out-of-order write-back, in-order commit
    issue(5'd1, 1'b0); issue(5'd2, 1'b0); issue(5'd3, 1'b0);
    wb(0, 3'd2, 64'h22);
    chk("t2_valid_00", cmt_valid_o, 64'b00);
    wb(1, 3'd0, 64'h20);
    chk("t2_valid_01", cmt_valid_o, 64'b01);
    wb(3, 3'd1, 64'h21);
    chk("t2_valid_11", cmt_valid_o, 64'b11);
    chk("t2_res1", cmt_entry_o[1].result, 64'h21);
    cmt_ack_i = 2'b11;
    tick();
    idle();
    chk("t2_count", count_o, 64'd1);
    chk("t2_tid", cmt_entry_o[0].tid, 64'd2);
    chk("t2_res2", cmt_entry_o[0].result, 64'h22);
    chk("t2_valid_last", cmt_valid_o, 64'b01);
    cmt_ack_i = 2'b01;
    tick();
    idle();
    chk("t2_count_0", count_o, 64'd0);
    do_flush();

    // 3: operand read picks the youngest producer
    issue(5'd5, 1'b0); issue(5'd5, 1'b0);
    rd_addr_i[0] = 5'd5; rd_fpr_i[0] = 1'b0;
    rd_addr_i[1] = 5'd5; rd_fpr_i[1] = 1'b1;
    #1;
    chk("t3_hit_pending", rd_hit_o[0], 64'd1);
    chk("t3_ready_pending", rd_ready_o[0], 64'd0);
    chk("t3_fpr_miss", rd_hit_o[1], 64'd0);
    wb(2, 3'd1, 64'hAA);
    chk("t3_hit", rd_hit_o[0], 64'd1);
    chk("t3_ready", rd_ready_o[0], 64'd1);
    chk("t3_data", rd_data_o[0], 64'hAA);
    wb(0, 3'd0, 64'h55);
    chk("t3_data_keep", rd_data_o[0], 64'hAA);
    issue(5'd0, 1'b0);
    rd_addr_i[1] = 5'd0; rd_fpr_i[1] = 1'b0;
    #1;
    chk("t3_x0_nohit", rd_hit_o[1], 64'd0);
    do_flush();

    // 6: write-back forwarding onto the read port
    issue(5'd7, 1'b0);
    rd_addr_i[0] = 5'd7; rd_fpr_i[0] = 1'b0;
    wb_valid_i[3] = 1'b1; wb_tid_i[3] = 3'd0; wb_data_i[3] = 64'h77;
    #1;
`ifdef SB_WB_FWD_EN
    chk("t6_fwd_ready", rd_ready_o[0], 64'd1);
    chk("t6_fwd_data", rd_data_o[0], 64'h77);
`else
    chk("t6_nofwd_ready", rd_ready_o[0], 64'd0);
`endif
    tick();
    idle();
    chk("t6_ready_next", rd_ready_o[0], 64'd1);
    chk("t6_data_next", rd_data_o[0], 64'h77);
    rd_addr_i = '0;
    do_flush();

    // 4: selective flush of entries younger than tid 2
    for (int i = 0; i < 6; i++) begin
      chk("t4_tid", iss_tid_o, 64'(i));
      issue(5'(10 + i), 1'b0);
    end
    flush_young_i = 1'b1; flush_tid_i = 3'd2; iss_valid_i = 1'b1;
    wb_valid_i[0] = 1'b1; wb_tid_i[0] = 3'd4; wb_data_i[0] = 64'h44;
    wb_valid_i[1] = 1'b1; wb_tid_i[1] = 3'd1; wb_data_i[1] = 64'h11;
    tick();
    idle();
    chk("t4_count", count_o, 64'd3);
    chk("t4_next_tid", iss_tid_o, 64'd3);
    wb(0, 3'd0, 64'h10);
    chk("t4_valid_11", cmt_valid_o, 64'b11);
    chk("t4_survivor_wb", cmt_entry_o[1].result, 64'h11);
    cmt_ack_i = 2'b11;
    tick();
    idle();
    chk("t4_count_1", count_o, 64'd1);
    chk("t4_valid_00", cmt_valid_o, 64'b00);
    chk("t4_reissue_tid3", iss_tid_o, 64'd3);
    issue(5'd20, 1'b0);
    chk("t4_reissue_tid4", iss_tid_o, 64'd4);
    issue(5'd21, 1'b0);
    chk("t4_count_3", count_o, 64'd3);
    wb(0, 3'd2, 64'h12);
    cmt_ack_i = 2'b01;
    tick();
    idle();
    chk("t4_count_2", count_o, 64'd2);
    wb(0, 3'd3, 64'h13);
    chk("t4_tid4_not_done", cmt_valid_o, 64'b01);
    chk("t4_tid4_rd", cmt_entry_o[1].iss.rd, 64'd21);
    do_flush();

    // 5: streaming issue/wb/commit across pointer wrap
    exp_iss = 0; exp_cmt = 0; prev_v = 1'b0; prev_n = 0;
    for (int c = 0; c < 26; c++) begin
      iss_valid_i = (c < 20);
      iss_entry_i = '0;
      iss_entry_i.rd = 5'd9;
      if (c < 20) chk("t5_tid", iss_tid_o, 64'(exp_iss % 8));
      wb_valid_i = '0;
      if (prev_v) begin
        wb_valid_i[0] = 1'b1;
        wb_tid_i[0] = TW'(prev_n % 8);
        wb_data_i[0] = 64'h100 + 64'(prev_n);
      end
      cmt_ack_i = {1'b0, cmt_valid_o[0]};
      if (cmt_valid_o[0]) begin
        chk("t5_cmt_tid", cmt_entry_o[0].tid, 64'(exp_cmt % 8));
        chk("t5_cmt_res", cmt_entry_o[0].result, 64'h100 + 64'(exp_cmt));
        exp_cmt++;
      end
      chk("t5_count_le8", 64'(count_o <= 4'd8), 64'd1);
      prev_v = (c < 20);
      prev_n = exp_iss;
      if (c < 20) exp_iss++;
      tick();
    end
    idle();
    chk("t5_all_committed", 64'(exp_cmt), 64'd20);
    chk("t5_drained", count_o, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
